// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   op_e     : CPU access types (4-bit encoding as seen on the op port)
//   state_e  : control FSM states
//   *_W      : lane/width constants
//   helpers  : op legality, store detection and alignment checks
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HALF_W    = 16;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_LANES = 4;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // LWL/LWR are deliberately unaligned word accesses, so they never fault.
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return lo != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the load/store unit.
//   op, lane     : registered access type and byte offset addr[1:0]
//   rt           : store data / old rt value for LWL/LWR merges
//   rdata        : bus read data (lane 0 = lowest address)
//   load_result  : extracted / extended / merged load value
//   byteenable   : lanes to drive (all four for any load)
//   writedata    : store data replicated onto the addressed lanes
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] rt,
  input  logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] load_result,
  output logic [3:0]        byteenable,
  output logic [WORD_W-1:0] writedata
);

  logic [BYTE_W-1:0] rd_byte;
  logic [HALF_W-1:0] rd_half;

  assign rd_byte = rdata[{lane, 3'b000} +: BYTE_W];
  assign rd_half = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_result = rdata;
    case (op)
      OP_LB:  load_result = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU: load_result = {24'd0, rd_byte};
      OP_LH:  load_result = {{16{rd_half[15]}}, rd_half};
      OP_LHU: load_result = {16'd0, rd_half};
      OP_LWL: begin
        case (lane)
          2'd0:    load_result = {rdata[7:0],  rt[23:0]};
          2'd1:    load_result = {rdata[15:0], rt[15:0]};
          2'd2:    load_result = {rdata[23:0], rt[7:0]};
          default: load_result = rdata;
        endcase
      end
      OP_LWR: begin
        case (lane)
          2'd0:    load_result = rdata;
          2'd1:    load_result = {rt[31:24], rdata[31:8]};
          2'd2:    load_result = {rt[31:16], rdata[31:16]};
          default: load_result = {rt[31:8],  rdata[31:24]};
        endcase
      end
      default: load_result = rdata;
    endcase
  end

  always_comb begin
    byteenable = 4'b1111;
    writedata  = rt;
    case (op)
      OP_SB: begin
        byteenable = 4'b0001 << lane;
        writedata  = {4{rt[7:0]}};
      end
      OP_SH: begin
        byteenable = lane[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{rt[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one CPU request per start strobe, runs a single
// bus read or write, and reports the result with a one-cycle done pulse.
//   clk, reset_n        : clock, asynchronous active-low reset
//   start, op, addr,    : CPU request (accepted only in IDLE)
//   rt_in
//   busy, done, err,    : CPU status / result
//   load_data
//   address, read,      : bus master side
//   write, byteenable,
//   writedata, readdata,
//   waitrequest
//   dbg_state           : current FSM state
//
// Bus handshake: in ACCESS exactly one of read/write is high with address,
// byteenable and writedata held stable; the transfer completes on the first
// ACCESS cycle where waitrequest is low (readdata is taken in that cycle).
// With TIMEOUT_CYCLES=N>0, N consecutive stalled cycles abort the transfer
// with err=1. load_data only changes when a load completes successfully.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] rt_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [3:0]        byteenable,
  output logic [WORD_W-1:0] writedata,
  input  logic [WORD_W-1:0] readdata,
  output logic [1:0]        dbg_state
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] rt_q, rt_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] load_data_q, load_data_d;
  logic              err_q, err_d;

  logic [WORD_W-1:0] lane_load;
  logic [WORD_W-1:0] lane_wdata;
  logic [3:0]        lane_be;
  logic              in_access;
  logic              is_store;
  logic              timeout_hit;

  lsu_lane_align u_lane_align (
    .op          (op_q),
    .lane        (addr_q[1:0]),
    .rt          (rt_q),
    .rdata       (readdata),
    .load_result (lane_load),
    .byteenable  (lane_be),
    .writedata   (lane_wdata)
  );

  assign in_access = (state_q == ST_ACCESS);
  assign is_store  = op_is_store(op_q);
  // cnt_q holds the stalled cycles already seen; this cycle is stall N.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && waitrequest &&
                       (cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    rt_d        = rt_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          addr_d = addr;
          rt_d   = rt_in;
          cnt_d  = '0;
          if (!op_is_legal(op) || op_misaligned(op, addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!waitrequest) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          if (!is_store) load_data_d = lane_load;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      rt_q        <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rt_q        <= rt_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
    end
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset removes them in the same cycle.
  assign read       = in_access && !is_store;
  assign write      = in_access && is_store;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_RESP);
  assign err        = err_q;
  assign load_data  = load_data_q;
  assign address    = {addr_q[31:2], 2'b00};
  assign byteenable = in_access ? lane_be : 4'b0000;
  assign writedata  = (in_access && is_store) ? lane_wdata : '0;
  assign dbg_state  = state_q;

endmodule
